// File: rtl/jtcps1_pkg.sv
// jtcps1_pkg: slot indices, FSM encoding and arbitration helpers for the VRAM slot responder.
package jtcps1_pkg;
    localparam logic [1:0] SLOT_SCR = 2'd0;
    localparam logic [1:0] SLOT_OBJ = 2'd1;
    localparam logic [1:0] SLOT_PAL = 2'd2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic logic [1:0] next_slot(input logic [1:0] s);
        return s == SLOT_PAL ? SLOT_SCR : s + 2'd1;
    endfunction

    // First requester at or after ptr, rotating 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_pick(input logic [2:0] need, input logic [1:0] ptr);
        logic [1:0] b, c;
        b = next_slot(ptr);
        c = next_slot(b);
        return need[ptr] ? ptr : need[b] ? b : c;
    endfunction

    function automatic logic [1:0] fixed_pick(input logic [2:0] need);
        return need[SLOT_PAL] ? SLOT_PAL : need[SLOT_SCR] ? SLOT_SCR : SLOT_OBJ;
    endfunction
endpackage

// File: rtl/jtcps1_vram_slot.sv
// jtcps1_vram_slot: one-word hit register for a single read-only requester.
module jtcps1_vram_slot #(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    input  logic          clear,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   din,
    output logic [15:0]   dout,
    output logic          ok,
    output logic          need
);
    logic [AW-1:0] lat_addr;
    logic          valid;
    logic          hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr <= '0;
            dout     <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            lat_addr <= load_addr;
            dout     <= din;
            valid    <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    assign hit  = valid && lat_addr == addr;
    assign ok   = cs && hit;
    assign need = cs && !hit;
endmodule

// File: rtl/jtcps1_vram_slots.sv
// jtcps1_vram_slots: three cached read slots (scroll, object, palette) sharing one
// memory read port, one outstanding fetch at a time.
module jtcps1_vram_slots
    import jtcps1_pkg::*;
#(
    parameter int AW = 17,
    parameter bit RR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] slot0_addr,
    input  logic          slot0_cs,
    output logic [15:0]   slot0_dout,
    output logic          slot0_ok,
    input  logic [AW-1:0] slot1_addr,
    input  logic          slot1_cs,
    output logic [15:0]   slot1_dout,
    output logic          slot1_ok,
    input  logic [AW-1:0] slot2_addr,
    input  logic          slot2_cs,
    output logic [15:0]   slot2_dout,
    output logic          slot2_ok,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic          mem_rdy,
    input  logic [15:0]   mem_din
);
    logic [AW-1:0] addr [3];
    logic [15:0]   dout [3];
    logic [2:0]    cs, ok, need;
    logic [1:0]    st, g, ptr, pick;
    logic          grant, take;

    assign addr[0] = slot0_addr;
    assign addr[1] = slot1_addr;
    assign addr[2] = slot2_addr;
    assign cs      = {slot2_cs, slot1_cs, slot0_cs};
    assign slot0_dout = dout[0];
    assign slot1_dout = dout[1];
    assign slot2_dout = dout[2];
    assign {slot2_ok, slot1_ok, slot0_ok} = ok;

    assign pick  = RR ? rr_pick(need, ptr) : fixed_pick(need);
    assign grant = st == ST_IDLE && |need;
    // Data may land in the ack cycle itself, so REQ can complete a fetch too.
    assign take  = mem_rdy && (st == ST_WAIT || (st == ST_REQ && mem_ack));

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_slot
            jtcps1_vram_slot #(.AW(AW)) u_slot (
                .clk       (clk),
                .rst       (rst),
                .addr      (addr[i]),
                .cs        (cs[i]),
                .clear     (grant && pick == 2'(i)),
                .load      (take && g == 2'(i)),
                .load_addr (mem_addr),
                .din       (mem_din),
                .dout      (dout[i]),
                .ok        (ok[i]),
                .need      (need[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            g        <= SLOT_SCR;
            ptr      <= SLOT_SCR;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (st)
                ST_IDLE: if (grant) begin
                    g        <= pick;
                    mem_addr <= addr[pick];
                    mem_rd   <= 1'b1;
                    st       <= ST_REQ;
                end
                ST_REQ: if (mem_ack) begin
                    mem_rd <= 1'b0;
                    st     <= mem_rdy ? ST_IDLE : ST_WAIT;
                    if (mem_rdy) ptr <= next_slot(g);
                end
                ST_WAIT: if (mem_rdy) begin
                    ptr <= next_slot(g);
                    st  <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule
